// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with the sign applied in a final cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;

  // Handshake: an op transfers on an edge with in_valid & in_ready (IDLE only, no flush);
  // a result transfers on an edge with out_valid & out_ready (DONE only).
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        op;
  logic              sign_a, sign_b;
  logic              forced;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result_q;

  // Accept-time decode
  logic              is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
  logic              div_zero, div_ovf, accept;
  logic [XLEN-1:0]   mag_a_in, mag_b_in, forced_val;

  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa_in       = a_signed_in & src_a[XLEN-1];
    sb_in       = b_signed_in & src_b[XLEN-1];
    mag_a_in    = sa_in ? -src_a : src_a;
    mag_b_in    = sb_in ? -src_b : src_b;
    div_zero    = is_div_in && (src_b == '0);
    div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                  (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    forced_val  = '0;
    if (div_zero)     forced_val = funct3[1] ? src_a : '1;
    else if (div_ovf) forced_val = funct3[1] ? '0 : src_a;
    accept      = in_valid && (state == IDLE) && !flush;
  end

  // One iteration step for each datapath; acc is {high, low} for both.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
    div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and field selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_val;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    fix_val  = acc[XLEN-1:0];
    if (!forced) begin
      case (op)
        3'b000:                 fix_val = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         fix_val = (sign_a ^ sign_b) ? -quo : quo;
        default:                fix_val = sign_a ? -rem : rem;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (div_zero || div_ovf) ? FIX : CALC;
      CALC: if (cnt == CW'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      forced   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op     <= funct3;
        sign_a <= sa_in;
        sign_b <= sb_in;
        cnt    <= '0;
        forced <= div_zero | div_ovf;
        opnd   <= is_div_in ? mag_b_in : mag_a_in;
        // Forced results ride through acc so FIX has a single source for result
        if (div_zero || div_ovf) acc <= {{XLEN{1'b0}}, forced_val};
        else                     acc <= {{XLEN{1'b0}}, is_div_in ? mag_a_in : mag_b_in};
      end else if (state == CALC && !flush) begin
        acc <= op[2] ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !flush) begin
        result_q <= fix_val;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

endmodule
